// File: rtl/agc_erasable_mem.sv
// Erasable memory: A/Q/Z/L flops at 0..3, synchronous RAM above; optional editing registers
// at 16..19 (CYR/SR/CYL/EDOP) when AGC_EDIT_REGS_EN is defined. Latency: request taken in IDLE
// at edge k, ack/rdata/addr_err valid in the cycle after edge k+1. One access in flight at a time.
module agc_erasable_mem #(
  parameter int unsigned ERASABLE_WORDS = 1024,
  parameter logic [14:0] RESET_Z        = 15'd2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [14:0] wdata,
  output logic [14:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        addr_err
);

  localparam int unsigned AW    = (ERASABLE_WORDS > 2) ? $clog2(ERASABLE_WORDS) : 1;
  localparam logic [12:0] WORDS = 13'(ERASABLE_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        latch_en;

  // Request captured at the accepting edge; inputs are ignored afterwards until IDLE.
  logic        we_q;
  logic [11:0] addr_q;
  logic [14:0] wdata_q;

  logic        in_range;
  logic        is_core;
  logic        is_edit;
  logic        is_ram;
  logic        do_access;
  logic        do_write;

  logic [14:0] reg_a;
  logic [14:0] reg_q;
  logic [14:0] reg_z;
  logic [14:0] reg_l;
  logic [14:0] reg_rd;

  logic [14:0] mem [0:ERASABLE_WORDS-1];
  logic [14:0] ram_rd;

  logic        ack_q;
  logic        busy_q;
  logic        err_q;
  logic        rd_q;
  logic        sel_ram_q;
  logic [14:0] reg_rd_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a fixed three-cycle walk once a request is accepted.
  always_comb begin
    state_nxt = state;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ACCESS;
          latch_en  = 1'b1;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (latch_en) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Address decode of the latched request.
  always_comb begin
    in_range  = ({1'b0, addr_q} < WORDS);
    is_core   = in_range && (addr_q[11:2] == 10'd0);
`ifdef AGC_EDIT_REGS_EN
    is_edit   = in_range && (addr_q[11:2] == 10'd4);
`else
    is_edit   = 1'b0;
`endif
    is_ram    = in_range && !is_core && !is_edit;
    do_access = (state == ACCESS);
    do_write  = do_access && we_q;
  end

  // Central registers A, Q, Z, L; Z restarts at the program entry address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_q <= '0;
      reg_z <= RESET_Z;
      reg_l <= '0;
    end else if (do_write && is_core) begin
      case (addr_q[1:0])
        2'd0: reg_a <= wdata_q;
        2'd1: reg_q <= wdata_q;
        2'd2: reg_z <= wdata_q;
        2'd3: reg_l <= wdata_q;
        default: ;
      endcase
    end
  end

`ifdef AGC_EDIT_REGS_EN
  logic [14:0] reg_cyr;
  logic [14:0] reg_sr;
  logic [14:0] reg_cyl;
  logic [14:0] reg_edop;

  // Editing registers transform the word on write; reads return the stored result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_cyr  <= '0;
      reg_sr   <= '0;
      reg_cyl  <= '0;
      reg_edop <= '0;
    end else if (do_write && is_edit) begin
      case (addr_q[1:0])
        2'd0: reg_cyr  <= {wdata_q[0], wdata_q[14:1]};
        2'd1: reg_sr   <= {wdata_q[14], wdata_q[14:1]};
        2'd2: reg_cyl  <= {wdata_q[13:0], wdata_q[14]};
        2'd3: reg_edop <= {7'd0, wdata_q[14:7]};
        default: ;
      endcase
    end
  end
`endif

  // Flop-register read mux; RAM words and out-of-range addresses read as zero here.
  always_comb begin
    reg_rd = '0;
    if (is_core) begin
      case (addr_q[1:0])
        2'd0: reg_rd = reg_a;
        2'd1: reg_rd = reg_q;
        2'd2: reg_rd = reg_z;
        2'd3: reg_rd = reg_l;
        default: reg_rd = '0;
      endcase
    end
`ifdef AGC_EDIT_REGS_EN
    if (is_edit) begin
      case (addr_q[1:0])
        2'd0: reg_rd = reg_cyr;
        2'd1: reg_rd = reg_sr;
        2'd2: reg_rd = reg_cyl;
        2'd3: reg_rd = reg_edop;
        default: reg_rd = '0;
      endcase
    end
`endif
  end

  // Single-port synchronous RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write && is_ram) mem[addr_q[AW-1:0]] <= wdata_q;
    if (do_access && !we_q && is_ram) ram_rd <= mem[addr_q[AW-1:0]];
  end

  // Registered response flags, set at the ACCESS edge so they cover exactly the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      sel_ram_q <= 1'b0;
      reg_rd_q  <= '0;
    end else begin
      ack_q     <= do_access;
      busy_q    <= (state_nxt != IDLE);
      err_q     <= do_access && !in_range;
      rd_q      <= do_access && !we_q;
      sel_ram_q <= do_access && is_ram;
      reg_rd_q  <= do_access ? reg_rd : '0;
    end
  end

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign addr_err = err_q;
  // rdata is forced to zero outside a read acknowledge, including during reset.
  assign rdata    = (ack_q && rd_q) ? (sel_ram_q ? ram_rd : reg_rd_q) : '0;

endmodule

// File: tb/tb_agc_erasable_mem.sv
// Self-checking bench for agc_erasable_mem: directed accesses against a word-level model.
// Per-cycle expectations are scheduled when a request is accepted and compared on the falling edge.
// Build with AGC_EDIT_REGS_EN defined to exercise the editing registers.
module tb_agc_erasable_mem;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [11:0] addr  = '0;
  logic [14:0] wdata = '0;
  logic [14:0] rdata;
  logic        ack;
  logic        busy;
  logic        addr_err;

`ifdef AGC_EDIT_REGS_EN
  localparam bit EDIT_EN = 1'b1;
`else
  localparam bit EDIT_EN = 1'b0;
`endif
  localparam int NCYC = 2048;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ack_cnt = 0;

  bit          exp_ack  [NCYC];
  bit          exp_busy [NCYC];
  bit          exp_err  [NCYC];
  bit          exp_rchk [NCYC];
  logic [14:0] exp_rd   [NCYC];
  logic [14:0] mdl      [4096];

  agc_erasable_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .ack      (ack),
    .busy     (busy),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  // Word-level model: what a write leaves in a location.
  function automatic logic [14:0] stored_val(input int a, input logic [14:0] d);
    int v;
    v = int'(d);
    if (EDIT_EN && a == 16) v = (v / 2) + (v % 2) * 16384;
    if (EDIT_EN && a == 17) v = (v / 2) + (v & 16384);
    if (EDIT_EN && a == 18) v = ((v * 2) % 32768) + (v / 16384);
    if (EDIT_EN && a == 19) v = v / 128;
    return v[14:0];
  endfunction

  task automatic model_do(input bit w, input int a, input logic [14:0] d,
                          output bit err, output logic [14:0] rd);
    err = (a >= 1024);
    rd  = '0;
    if (!err) begin
      if (w) mdl[a] = stored_val(a, d);
      else   rd = mdl[a];
    end
  endtask

  task automatic model_reset();
    mdl[0] = '0;
    mdl[1] = '0;
    mdl[2] = 15'd2048;
    mdl[3] = '0;
    if (EDIT_EN) for (int i = 16; i < 20; i++) mdl[i] = '0;
  endtask

  task automatic clear_exp(input int from);
    for (int i = from; i < from + 4; i++) begin
      exp_ack[i]  = 1'b0;
      exp_busy[i] = 1'b0;
      exp_err[i]  = 1'b0;
      exp_rchk[i] = 1'b0;
    end
  endtask

  // mode: 0 plain, 1 change inputs while busy, 2 reset during ACCESS, 3 reset during RESP
  task automatic access(input bit w, input int a, input logic [14:0] d, input int mode,
                        output logic [14:0] rd_dut, output bit err_dut);
    int          k;
    bit          e;
    logic [14:0] r;
    rd_dut  = '0;
    err_dut = 1'b0;
    @(negedge clk);
    req   = 1'b1;
    we    = w;
    addr  = 12'(a);
    wdata = d;
    @(posedge clk);
    #1;
    k = cyc;
    if (mode == 2) begin
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("abort_access_busy", 32'(busy), 0);
      chk("abort_access_ack", 32'(ack), 0);
      model_reset();
      clear_exp(k);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    model_do(w, a, d, e, r);
    exp_busy[k]   = 1'b1;
    exp_busy[k+1] = 1'b1;
    exp_ack[k+1]  = 1'b1;
    exp_err[k+1]  = e;
    exp_rchk[k+1] = !w;
    exp_rd[k+1]   = r;
    if (mode == 1) begin
      @(negedge clk);
      addr  = ~addr;
      wdata = ~wdata;
    end
    @(posedge clk);
    #1;
    rd_dut  = rdata;
    err_dut = addr_err;
    if (mode == 3) begin
      chk("resp_ack_before_rst", 32'(ack), 1);
      #1;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      chk("rst_ack_drop", 32'(ack), 0);
      chk("rst_busy_drop", 32'(busy), 0);
      chk("rst_rdata_zero", 32'(rdata), 0);
      model_reset();
      clear_exp(k + 1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    req = 1'b0;
    we  = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Per-cycle comparison of every output against the scheduled expectation.
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("ack", 32'(ack), 32'(exp_ack[cyc]));
      chk("busy", 32'(busy), 32'(exp_busy[cyc]));
      chk("addr_err", 32'(addr_err), 32'(exp_ack[cyc] & exp_err[cyc]));
      if (exp_ack[cyc] && exp_rchk[cyc]) chk("rdata", 32'(rdata), 32'(exp_rd[cyc]));
      else if (!exp_ack[cyc])            chk("rdata_idle", 32'(rdata), 0);
    end
    if (ack) ack_cnt++;
  end

  initial begin
    logic [14:0] r;
    bit          e;
    int          c0;
    logic [14:0] ed_in  [4];
    logic [14:0] ed_out [4];
    ed_in[0] = 15'h0001; ed_out[0] = 15'h4000;
    ed_in[1] = 15'h4000; ed_out[1] = 15'h6000;
    ed_in[2] = 15'h4000; ed_out[2] = 15'h0001;
    ed_in[3] = 15'h3F80; ed_out[3] = 15'h007F;

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(addr_err), 0);
    chk("rst_rdata", 32'(rdata), 0);
    rst_n = 1'b1;
    idle(2);

    access(1'b0, 2, '0, 0, r, e);
    chk("rd_z", 32'(r), 2048);
    chk("rd_z_err", 32'(e), 0);
    access(1'b0, 0, '0, 0, r, e);
    chk("rd_a", 32'(r), 0);
    idle(1);

    // req held high across four back-to-back accesses
    c0 = ack_cnt;
    access(1'b1, 100, 15'h5A5A, 0, r, e);
    access(1'b0, 100, '0, 0, r, e);
    chk("raw_100", 32'(r), 32'h5A5A);
    access(1'b1, 4, 15'h7FFF, 0, r, e);
    access(1'b0, 4, '0, 0, r, e);
    chk("raw_4", 32'(r), 32'h7FFF);
    chk("b2b_acks", 32'(ack_cnt - c0), 4);
    idle(2);

    access(1'b1, 1030, 15'h1234, 0, r, e);
    chk("oor_wr_err", 32'(e), 1);
    access(1'b0, 1030, '0, 0, r, e);
    chk("oor_rd_data", 32'(r), 0);
    chk("oor_rd_err", 32'(e), 1);
    access(1'b1, 1023, 15'h2AAA, 0, r, e);
    access(1'b0, 1023, '0, 0, r, e);
    chk("last_word", 32'(r), 32'h2AAA);
    chk("last_word_err", 32'(e), 0);
    access(1'b0, 1024, '0, 0, r, e);
    chk("first_oor_err", 32'(e), 1);

    access(1'b1, 0, 15'h7ABC, 0, r, e);
    access(1'b1, 1, 15'h0155, 0, r, e);
    access(1'b1, 3, 15'h4321, 0, r, e);
    access(1'b0, 0, '0, 0, r, e);
    chk("reg_a", 32'(r), 32'h7ABC);
    access(1'b0, 1, '0, 0, r, e);
    chk("reg_q", 32'(r), 32'h0155);
    access(1'b0, 3, '0, 0, r, e);
    chk("reg_l", 32'(r), 32'h4321);
    idle(1);

    for (int i = 0; i < 4; i++) begin
      access(1'b1, 16 + i, ed_in[i], 0, r, e);
      access(1'b0, 16 + i, '0, 0, r, e);
      chk("edit_reg", 32'(r), EDIT_EN ? 32'(ed_out[i]) : 32'(ed_in[i]));
    end

    access(1'b1, 50, 15'h0F0F, 1, r, e);
    access(1'b0, 50, '0, 1, r, e);
    chk("latched_req", 32'(r), 32'h0F0F);
    chk("latched_req_err", 32'(e), 0);
    idle(1);

    access(1'b1, 200, 15'h1111, 0, r, e);
    access(1'b1, 200, 15'h2222, 2, r, e);
    access(1'b0, 200, '0, 0, r, e);
    chk("abort_wr_lost", 32'(r), 32'h1111);
    access(1'b0, 0, '0, 0, r, e);
    chk("a_after_rst", 32'(r), 0);

    access(1'b1, 3, 15'h7FFF, 3, r, e);
    access(1'b0, 3, '0, 0, r, e);
    chk("l_after_rst", 32'(r), 0);
    access(1'b0, 2, '0, 0, r, e);
    chk("z_after_rst", 32'(r), 2048);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/agc_erasable_mem.md
AGC_ERASABLE_MEM -- requirements
Module: agc_erasable_mem

Interface
REQ-001 Parameter ERASABLE_WORDS, 1024: erasable words served at addr 0..ERASABLE_WORDS-1.
REQ-002 Parameter RESET_Z, 15'd2048: Z register value after reset (start address 04000 octal).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access request; held high by initiator until ack.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  12  word address; sampled with req.
REQ-008 wdata  input  15  write data; sampled with req.
REQ-009 rdata  output  15  read data, valid only while ack=1.
REQ-010 ack  output  1  one-cycle completion pulse.
REQ-011 busy  output  1  high while state is not IDLE.
REQ-012 addr_err  output  1  high with ack when the completed access address is >= ERASABLE_WORDS.

Function
REQ-013 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when req=1; ACCESS->RESP unconditionally; RESP->IDLE unconditionally.
REQ-014 In IDLE with req=1 at edge k: addr, we, wdata latched into internal registers; later input changes are ignored until IDLE.
REQ-015 ACCESS (edge k+1): write performed or read data captured; RESP (edge k+2): ack=1, rdata and addr_err valid for exactly that one cycle.
REQ-016 Minimum request spacing is 3 cycles; req still high in IDLE after ack starts a new access.
REQ-017 Addresses 0,1,2,3 map to flop registers A, Q, Z, L, not to RAM.
REQ-018 Addresses 4..ERASABLE_WORDS-1 map to synchronous single-port RAM, 15-bit words.
REQ-019 Out-of-range address: write ignored, rdata=0, addr_err=1 in the RESP cycle.
REQ-020 Writes store all 15 bits unmodified, except editing registers (REQ-027..030).
REQ-021 Read-after-write to the same address in consecutive accesses returns the new value.
REQ-022 ack, busy, addr_err are registered outputs, no combinational path from req.
REQ-023 rdata=0 in every cycle ack=0.

Reset
REQ-024 rst_n low: state=IDLE, ack=0, busy=0, addr_err=0, rdata=0 immediately, independent of clk.
REQ-025 rst_n low: A=Q=L=0, Z=RESET_Z; RAM contents not reset.
REQ-026 Reset asserted during ACCESS or RESP aborts the access: no ack issued; a write not yet committed at ACCESS edge is lost.

Configuration
REQ-027 Macro AGC_EDIT_REGS_EN: when defined, addresses 16..19 are editing registers CYR, SR, CYL, EDOP held in flops, reset to 0.
REQ-028 With AGC_EDIT_REGS_EN: write to CYR stores wdata rotated right 1 (bit0->bit14); SR stores wdata shifted right 1 with bit14 replicated.
REQ-029 With AGC_EDIT_REGS_EN: write to CYL stores wdata rotated left 1 (bit14->bit0); EDOP stores wdata>>7, bits 14:8 zero.
REQ-030 With AGC_EDIT_REGS_EN: reads of 16..19 return stored edited value; without the macro, 16..19 are plain RAM words and no editing logic exists.

Verification
REQ-031 Reset release, read addr 2 -> ack 2 edges after req sampled, rdata=15'd2048, addr_err=0; read addr 0 -> rdata=0.
REQ-032 Write addr 100 data 15'h5A5A, then read addr 100 -> rdata=15'h5A5A; req held high continuously -> ack every 3rd cycle.
REQ-033 Write addr 1030 data 15'h1234 -> ack with addr_err=1; read addr 1030 -> rdata=0, addr_err=1.
REQ-034 With macro: write CYR=15'h0001 -> read 15'h4000; SR=15'h4000 -> 15'h6000; CYL=15'h4000 -> 15'h0001; EDOP=15'h3F80 -> 15'h007F. Without macro: same writes read back unchanged.
REQ-035 Assert rst_n low during RESP of a write to addr 3 (data 15'h7FFF) -> ack drops same cycle, L reads 0 after release.
REQ-036 Change addr/wdata while busy=1 -> completed access uses values latched at the request edge.
